// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the multi-cycle MULT/MULTU/DIV/DIVU unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIXUP,
    S_DONE
  } md_state_e;

  localparam int MD_STEPS = 32;

  // Two's-complement negate when neg is set; used for abs() and sign fixup.
  function automatic logic [31:0] cond_neg(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiply / restoring divide datapath with sign pre- and post-processing.
// The divider is compiled in only when MULDIV_DIV_EN is defined.
module muldiv_datapath
  import muldiv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        latch_i,
  input  logic        prep_i,
  input  logic        step_i,
  input  md_op_e      op_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o
);

  md_op_e      op_q;
  logic [64:0] sh_q;  // {carry, acc / remainder, multiplier / quotient}
  logic [31:0] opnd_q;
  logic        neg1_q;
  logic        neg2_q;
  logic        is_signed;
  logic [32:0] add_a;
  logic [32:0] add_b;
  logic        add_cin;
  logic [33:0] add_sum;
  logic [64:0] sh_d;
  logic [63:0] prod_fix;

`ifdef MULDIV_DIV_EN
  logic        is_div;
  logic        div0_q;
  assign is_div = (op_q == MD_DIV) || (op_q == MD_DIVU);
`endif

  assign is_signed = (op_q == MD_MULT) || (op_q == MD_DIV);

  // Shared 33-bit adder: accumulate for multiply, trial-subtract for divide.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path infers a latch.
    add_a   = {sh_q[64], sh_q[63:32]};
    add_b   = {1'b0, sh_q[0] ? opnd_q : 32'd0};
    add_cin = 1'b0;
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      add_a   = {sh_q[63:32], sh_q[31]};
      add_b   = ~{1'b0, opnd_q};
      add_cin = 1'b1;
    end
`endif
  end

  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {33'd0, add_cin};

  // Multiply shifts {carry, acc, mq} right; divide keeps the remainder when the
  // trial subtraction does not borrow (add_sum[33] set) and shifts a quotient bit in.
  always_comb begin
    sh_d = {add_sum[33:0], sh_q[31:1]};
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      sh_d = {1'b0, add_sum[33] ? add_sum[31:0] : add_a[31:0], sh_q[30:0], add_sum[33]};
    end
`endif
  end

  assign prod_fix = (is_signed && (neg1_q != neg2_q)) ? (~sh_q[63:0] + 64'd1) : sh_q[63:0];

  // A zero divisor keeps quotient all-ones and the remainder regains the dividend's sign.
  always_comb begin
    res_hi_o = prod_fix[63:32];
    res_lo_o = prod_fix[31:0];
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      res_lo_o = cond_neg(is_signed && (neg1_q != neg2_q) && !div0_q, sh_q[31:0]);
      res_hi_o = cond_neg(is_signed && neg1_q, sh_q[63:32]);
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q   <= MD_MULT;
      sh_q   <= '0;
      opnd_q <= '0;
      neg1_q <= 1'b0;
      neg2_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      div0_q <= 1'b0;
`endif
    end else if (latch_i) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      op_q   <= op_i;
      sh_q   <= {33'd0, data1_i};
      opnd_q <= data2_i;
    end else if (prep_i) begin
      neg1_q <= is_signed && sh_q[31];
      neg2_q <= is_signed && opnd_q[31];
      sh_q   <= {33'd0, cond_neg(is_signed && sh_q[31], sh_q[31:0])};
      opnd_q <= cond_neg(is_signed && opnd_q[31], opnd_q);
`ifdef MULDIV_DIV_EN
      div0_q <= (opnd_q == 32'd0);
`endif
    end else if (step_i) begin
      sh_q <= sh_d;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit: FSM, iteration counter, HI/LO and stall handshake.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic             accept;
  logic             go_prep;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;

  assign accept = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef MULDIV_DIV_EN
  assign go_prep = accept;
`else
  // Without a divider, divides retire straight to DONE and leave HI/LO untouched.
  assign go_prep = accept && !op_i[1];
`endif

  muldiv_datapath u_datapath (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .latch_i  (go_prep),
    .prep_i   (state_q == S_PREP),
    .step_i   (state_q == S_ITER),
    .op_i     (md_op_e'(op_i)),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .res_hi_o (res_hi),
    .res_lo_o (res_lo)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (go_prep) begin
            state_q <= S_PREP;
            busy_q  <= 1'b1;
          end else if (accept) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_PREP: begin
          state_q <= S_ITER;
          cnt_q   <= CNT_W'(MD_STEPS);
        end
        S_ITER: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= S_FIXUP;
        end
        S_FIXUP: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
